// File: rtl/regfile_param.sv
// Purpose : parametrised register file (DATA_W x 2**ADDR_W, NUM_RD combinational read
//           ports) with a post-reset clear sequencer, busy flag and sticky dropped-write error.
// Latency : write 1 clk; read 0 clk (combinational). Optional same-cycle write-to-read bypass
//           when the macro REGFILE_BYPASS_EN is defined (default build: no bypass).
// Backpr. : no flow control; writes presented while busy=1 are dropped and latch wr_err.
//
// Ports:
//   clk, rst_n              single clock, synchronous active-low reset
//   regWrite/writeReg/writeData  write port
//   rr        packed read addresses, port k = rr[k*ADDR_W +: ADDR_W]
//   readData  packed read data,      port k = readData[k*DATA_W +: DATA_W]
//   busy      1 while in reset or clearing
//   wr_err    sticky, set by a write attempted while busy; cleared only by reset

module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [NUM_RD*ADDR_W-1:0]   rr,
    output logic [NUM_RD*DATA_W-1:0]   readData,
    output logic                       busy,
    output logic                       wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;   // DEPTH-1

    typedef enum logic [1:0] {
        ST_RST,
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                wr_err_q, wr_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                wr_to_zero;

    // Entry 0 is hardwired when ZERO_REG is set, so a write to it is silently discarded.
    assign wr_to_zero = (ZERO_REG != 0) && (writeReg == '0);

    // Next-state logic for the sequencer, the error flag and the single array write port.
    // The clear sequencer and the user write share that port; they never overlap because
    // user writes are only accepted in READY.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr_err_d = wr_err_q;
        mem_we   = 1'b0;
        mem_wa   = writeReg;
        mem_wd   = writeData;

        case (state_q)
            ST_RST: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = '0;
                ptr_d  = ptr_q + 1'b1;
                // Terminal count at DEPTH-1: the last entry is written this edge and the
                // sequencer leaves before the pointer can start a second pass.
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (regWrite && !wr_to_zero) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST;
                ptr_d   = '0;
            end
        endcase

        if (regWrite && busy_q) begin
            wr_err_d = 1'b1;
        end

        // busy is a registered decode of the state being entered.
        busy_d = (state_d != ST_READY);
    end

    // Sequencer and status flops; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Storage array: never reset directly, only zeroed by the clear sequencer.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Combinational read ports. Busy and zero-register masking override any forwarded value.
    always_comb begin
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;
        readData = '0;
        rd_addr  = '0;
        rd_val   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr = rr[k*ADDR_W +: ADDR_W];
            rd_val  = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if ((state_q == ST_READY) && regWrite && (writeReg == rd_addr) && !wr_to_zero) begin
                rd_val = writeData;
            end
`endif
            if (busy_q || ((ZERO_REG != 0) && (rd_addr == '0))) begin
                rd_val = '0;
            end
            readData[k*DATA_W +: DATA_W] = rd_val;
        end
    end

    assign busy   = busy_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 32x32 / 2-port instance plus a
// 16-bit x 8-entry / 4-port / ZERO_REG=0 instance sharing the same clock.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst_n     = 1'b0;
    logic        regWrite  = 1'b0;
    logic [4:0]  writeReg  = '0;
    logic [31:0] writeData = '0;
    logic [9:0]  rr        = '0;
    logic [63:0] readData;
    logic        busy;
    logic        wr_err;

    regfile_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .rr        (rr),
        .readData  (readData),
        .busy      (busy),
        .wr_err    (wr_err)
    );

    // Swept-parameter instance
    logic        rst_n2     = 1'b0;
    logic        regWrite2  = 1'b0;
    logic [2:0]  writeReg2  = '0;
    logic [15:0] writeData2 = '0;
    logic [11:0] rr2        = '0;
    logic [63:0] readData2;
    logic        busy2;
    logic        wr_err2;

    regfile_param #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .NUM_RD   (4),
        .ZERO_REG (0)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n2),
        .regWrite  (regWrite2),
        .writeReg  (writeReg2),
        .writeData (writeData2),
        .rr        (rr2),
        .readData  (readData2),
        .busy      (busy2),
        .wr_err    (wr_err2)
    );

    int checks   = 0;
    int failures = 0;
    int n;
    logic [31:0] exp_byp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clock the default instance until busy falls; optionally inject a write to r7
    // sampled at edge number err_at (counted from the first edge with rst_n=1).
    task automatic wait_ready1(input int err_at, output int edges);
        edges = 0;
        while (edges < 200) begin
            if (edges + 1 == err_at) begin
                regWrite  = 1'b1;
                writeReg  = 5'd7;
                writeData = 32'h0000_7777;
            end else begin
                regWrite = 1'b0;
            end
            step();
            edges++;
            if (!busy) break;
        end
        regWrite = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rr = {a[4:0], a[4:0]};
            #1;
            chk($sformatf("%s_a%0d", tag, a), readData, 64'h0);
        end
    endtask

    initial begin
        // ---------------- reset + first clear ----------------
        rr = {5'd7, 5'd5};
        repeat (3) step();
        chk("rst_busy", {63'h0, busy}, 64'h1);
        chk("rst_wr_err", {63'h0, wr_err}, 64'h0);
        chk("rst_readdata", readData, 64'h0);

        rst_n = 1'b1;
        wait_ready1(0, n);
        chk("clear_edges", 64'(n), 64'd33);
        chk("ready_busy", {63'h0, busy}, 64'h0);
        chk("ready_wr_err", {63'h0, wr_err}, 64'h0);
        check_all_zero("clr1");

        // ---------------- basic write/read ----------------
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
        step();
        regWrite = 1'b0;
        rr = {5'd5, 5'd5};
        #1;
        chk("r5_p0", {32'h0, readData[31:0]}, {32'h0, 32'hDEAD_BEEF});
        chk("r5_p1", {32'h0, readData[63:32]}, {32'h0, 32'hDEAD_BEEF});

        // Write to r0 is discarded, read back as 0 and raises no error; also check
        // zero masking wins over same-cycle forwarding.
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h0000_1234;
        rr = {5'd0, 5'd0};
        #1;
        chk("r0_same_cycle", readData, 64'h0);
        step();
        regWrite = 1'b0;
        #1;
        chk("r0_after", readData, 64'h0);
        chk("r0_no_err", {63'h0, wr_err}, 64'h0);

        // ---------------- same-cycle read of the written address ----------------
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5_A5A5;
`else
        exp_byp = 32'h0;
`endif
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5A5_A5A5;
        rr = {5'd5, 5'd3};
        #1;
        chk("r3_same_cycle", {32'h0, readData[31:0]}, {32'h0, exp_byp});
        chk("r5_other_port", {32'h0, readData[63:32]}, {32'h0, 32'hDEAD_BEEF});
        step();
        regWrite = 1'b0;
        #1;
        chk("r3_next_cycle", {32'h0, readData[31:0]}, {32'h0, 32'hA5A5_A5A5});

        // ---------------- fill, then reset mid-clear ----------------
        for (int i = 1; i < 32; i++) begin
            regWrite = 1'b1; writeReg = i[4:0]; writeData = 32'h1000_0000 + i;
            step();
        end
        regWrite = 1'b0;
        rr = {5'd1, 5'd31};
        #1;
        chk("fill_r31", {32'h0, readData[31:0]}, {32'h0, 32'h1000_001F});
        chk("fill_r1", {32'h0, readData[63:32]}, {32'h0, 32'h1000_0001});

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            regWrite = (i == 10);
            writeReg = 5'd7; writeData = 32'h0000_7777;
            step();
        end
        regWrite = 1'b0;
        chk("mid_clear_busy", {63'h0, busy}, 64'h1);
        chk("mid_clear_wr_err", {63'h0, wr_err}, 64'h1);
        chk("mid_clear_rd_masked", readData, 64'h0);

        rst_n = 1'b0;
        step();
        chk("mid_rst_wr_err", {63'h0, wr_err}, 64'h0);
        chk("mid_rst_busy", {63'h0, busy}, 64'h1);
        rst_n = 1'b1;
        wait_ready1(0, n);
        chk("restart_edges", 64'(n), 64'd33);
        check_all_zero("clr2");
        chk("restart_wr_err", {63'h0, wr_err}, 64'h0);

        // ---------------- sticky error from a write during CLEAR ----------------
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_ready1(10, n);
        chk("err_clear_edges", 64'(n), 64'd33);
        chk("err_set", {63'h0, wr_err}, 64'h1);
        rr = {5'd7, 5'd7};
        #1;
        chk("err_r7_zero", readData, 64'h0);
        regWrite = 1'b1; writeReg = 5'd8; writeData = 32'h0000_0088;
        step();
        regWrite = 1'b0;
        step();
        chk("err_sticky", {63'h0, wr_err}, 64'h1);
        rst_n = 1'b0;
        step();
        chk("err_cleared", {63'h0, wr_err}, 64'h0);
        rst_n = 1'b1;

        // ---------------- parameter sweep instance ----------------
        rst_n2 = 1'b1;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (!busy2) break;
        end
        chk("p2_clear_edges", 64'(n), 64'd9);
        rr2 = {3'd0, 3'd0, 3'd0, 3'd0};
        #1;
        chk("p2_r0_cleared", readData2, 64'h0);
        regWrite2 = 1'b1; writeReg2 = 3'd0; writeData2 = 16'hBEEF;
        step();
        regWrite2 = 1'b0;
        #1;
        chk("p2_r0_all_ports", readData2, {4{16'hBEEF}});
        chk("p2_wr_err", {63'h0, wr_err2}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the single-cycle MIPS datapath. It generalises the fixed 32×32, two-read-port file to configurable data width, depth and read-port count. It adds a synchronous clear sequencer that zeroes every entry after reset, a busy indication, a sticky error flag for writes dropped while busy, and optional write-to-read bypass. It sits between instruction decode (register specifiers) and the ALU/writeback mux.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes; when 0 entry 0 is an ordinary register

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- regWrite  in  1  write enable
- writeReg  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- rr  in  NUM_RD*ADDR_W  packed read addresses; port k = rr[k*ADDR_W +: ADDR_W]
- readData  out  NUM_RD*DATA_W  packed read data; port k = readData[k*DATA_W +: DATA_W]
- busy  out  1  1 while in reset or clearing; writes are not accepted
- wr_err  out  1  sticky; set when regWrite=1 is sampled while busy=1

## Operation
- Sequencer states: RST, CLEAR, READY.
  - rst_n=0 sampled at an edge → RST.
  - RST with rst_n=1 → CLEAR, clear pointer = 0.
  - CLEAR writes 0 to entry[ptr] and increments ptr each cycle. When ptr == DEPTH-1, that entry is written and the next state is READY.
  - READY persists until rst_n=0.
- busy = 1 in RST and CLEAR, 0 in READY. This is a registered state decode.
- Writes in READY: if regWrite=1, entry[writeReg] ← writeData at the edge. With ZERO_REG=1, a write to address 0 is discarded; it is not an error.
- Writes while busy are dropped, and wr_err ← 1. wr_err clears only when rst_n=0 is sampled.
- Reads are combinational per port:
  - readData_k = 0 if busy=1.
  - readData_k = 0 if ZERO_REG=1 and rr_k==0.
  - otherwise readData_k = entry[rr_k], or the bypass value (see Configuration).
- Ports are independent. Any number of ports may address the same entry.
- Reset mid-CLEAR: the sequencer returns to RST and the pointer restarts from 0. A full clear always completes before READY.
- Array contents are not reset directly; only the sequencer zeroes them.

## Timing
- Reset values, from the edge where rst_n=0 is sampled: busy=1, wr_err=0, readData=all zeros, state=RST, ptr=0.
- The first edge with rst_n=1 enters CLEAR. busy falls exactly DEPTH+1 edges after rst_n is first sampled high (1 for RST→CLEAR, DEPTH clear writes).
- Write latency: 1 clock. Data written at edge n is visible on reads from edge n onward.
- Read latency: 0 (combinational), when bypass is disabled.
- Simultaneous read and write of the same address in the same cycle:
  - without bypass, the read returns the old value;
  - with bypass, it returns writeData.
- Pointer arithmetic is ADDR_W bits wide. The terminal count is detected at DEPTH-1, so the pointer never wraps into a second pass.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: when state=READY, regWrite=1, writeReg==rr_k, and not (ZERO_REG=1 and writeReg==0), readData_k = writeData combinationally in the same cycle.
- Undefined: no forwarding; same-cycle reads return the pre-write array value. The decode stage then must not depend on same-cycle visibility.
- Busy and zero-register masking take precedence over bypass in both builds.

## Test plan
- Reset for 3 cycles, release → busy stays 1 for exactly 33 edges (DEPTH=32), then 0; all 32 addresses read 0.
- In READY: write 0xDEADBEEF to r5, then read r5 on port0 and port1 → both 0xDEADBEEF; write 0x1234 to r0 → reads 0 (ZERO_REG=1), wr_err stays 0.
- regWrite=1 to r7 during CLEAR (cycle 10) → wr_err=1 and stays 1; r7 reads 0 after busy falls; wr_err clears only after rst_n=0.
- Write r3=0xA5A5A5A5 while rr port0=3 in the same cycle:
  - with REGFILE_BYPASS_EN, port0=0xA5A5A5A5 that cycle;
  - without it, port0=old value (0), then 0xA5A5A5A5 next cycle.
- Fill r1..r31 with nonzero values, assert rst_n=0 at cycle 15 of the following clear, release → clear restarts at ptr 0, busy is 1 for a further 33 edges, all entries read 0.
- Parameter sweep DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=0 → busy lasts 9 edges; a write of 0xBEEF to r0 is read back on all 4 ports.
